// File: rtl/pkt_fifo_pkg.sv
// Shared types, defaults and arbitration helper for the packet FIFO bank.
// Imported by the interface, the channel FIFO and the bank top.
package pkt_fifo_pkg;

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 4;
    localparam int MAX_CH     = 32;

    // First requester after 'last', wrapping over n channels; holds 'last' if none.
    function automatic int rr_pick(
        input logic [MAX_CH-1:0] req,
        input int                last,
        input int                n
    );
        int   g;
        int   idx;
        logic hit;
        g   = last;
        hit = 1'b0;
        for (int i = 1; i <= MAX_CH; i++) begin
            idx = (last + i) % n;
            if (i <= n && !hit && req[idx[4:0]]) begin
                g   = idx;
                hit = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/pkt_fifo_bank_if.sv
// Producer/consumer bundle of the packet FIFO bank.
// The slave side is the bank; the master side drives pushes and accepts output.
interface pkt_fifo_bank_if
    import pkt_fifo_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]             in_valid;
    logic [NUM_CH-1:0]             in_ready;
    logic [NUM_CH-1:0][DATA_W-1:0] in_data;
    logic [NUM_CH-1:0][TAG_W-1:0]  in_tag;
    logic [NUM_CH-1:0]             flush;
    logic [NUM_CH-1:0][CNT_W-1:0]  level;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_W-1:0]             out_data;
    logic [TAG_W-1:0]              out_tag;
    logic [CH_W-1:0]               out_ch;

    modport master (
        output in_valid, in_data, in_tag, flush, out_ready,
        input  in_ready, level, out_valid, out_data, out_tag, out_ch
    );

    modport slave (
        input  in_valid, in_data, in_tag, flush, out_ready,
        output in_ready, level, out_valid, out_data, out_tag, out_ch
    );

endinterface

// File: rtl/pkt_fifo_chan.sv
// Single-channel FIFO: push, pop, flush, occupancy count and head word.
// Control state is reset; the storage array is not.
module pkt_fifo_chan
    import pkt_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = DEF_DATA_W + DEF_TAG_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 wdata,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // A full channel refuses pushes even when it is popped on the same edge.
    assign push_ok = push && (count_q != CNT_W'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pkt_fifo_bank.sv
// NUM_CH packet FIFOs drained round-robin into one registered
// valid/ready output, with per-channel flush and level reporting.
module pkt_fifo_bank
    import pkt_fifo_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input logic             clk,
    input logic             rst_n,
    pkt_fifo_bank_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PW    = TAG_W + DATA_W;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } payload_t;

    logic [NUM_CH-1:0]            push_v;
    logic [NUM_CH-1:0]            pop_v;
    logic [NUM_CH-1:0]            flush_v;
    logic [NUM_CH-1:0]            req;
    logic [NUM_CH-1:0][PW-1:0]    wdata_p;
    logic [NUM_CH-1:0][PW-1:0]    head_p;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_p;
    logic [CH_W-1:0]              grant;
    logic                         slot_free;

    out_state_e       state_q, state_d;
    payload_t         out_pl_q, out_pl_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;
    logic [CH_W-1:0]  rr_q, rr_d;

    assign push_v  = bus.in_valid;
    assign flush_v = bus.flush;

    always_comb begin
        wdata_p = '0;
        req     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wdata_p[c] = {bus.in_tag[c], bus.in_data[c]};
            // A channel being flushed sits out arbitration this edge.
            req[c]     = (cnt_p[c] != '0) && !flush_v[c];
        end
    end

    pkt_fifo_chan #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_chan [NUM_CH] (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_v),
        .pop   (pop_v),
        .flush (flush_v),
        .wdata (wdata_p),
        .head  (head_p),
        .count (cnt_p)
    );

    assign slot_free = (state_q == OUT_EMPTY) || bus.out_ready;
    assign grant     = CH_W'(rr_pick(MAX_CH'(req), int'(rr_q), NUM_CH));

    always_comb begin
        state_d  = state_q;
        out_pl_d = out_pl_q;
        out_ch_d = out_ch_q;
        rr_d     = rr_q;
        pop_v    = '0;
        if (slot_free) begin
            if (|req) begin
                pop_v[grant] = 1'b1;
                out_pl_d     = payload_t'(head_p[grant]);
                out_ch_d     = grant;
                rr_d         = grant;
                state_d      = OUT_FULL;
            end else begin
                state_d = OUT_EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= OUT_EMPTY;
            out_pl_q <= '0;
            out_ch_q <= '0;
            rr_q     <= CH_W'(NUM_CH - 1);
        end else begin
            state_q  <= state_d;
            out_pl_q <= out_pl_d;
            out_ch_q <= out_ch_d;
            rr_q     <= rr_d;
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.in_ready[c] = (cnt_p[c] != CNT_W'(DEPTH));
        end
    end

    assign bus.level     = cnt_p;
    assign bus.out_valid = (state_q == OUT_FULL);
    assign bus.out_data  = out_pl_q.data;
    assign bus.out_tag   = out_pl_q.tag;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_pkt_fifo_bank.sv
// Directed bench for pkt_fifo_bank: latency, fill, round-robin,
// stall, flush and mid-operation reset with hand-computed expectations.
module tb_pkt_fifo_bank;
    import pkt_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pkt_fifo_bank_if bus ();

    pkt_fifo_bank u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_out(input string tag, input int ch, input logic [31:0] d, input int t);
        chk({tag, ".v"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".ch"}, 64'(bus.out_ch), 64'(ch));
        chk({tag, ".d"}, 64'(bus.out_data), 64'(d));
        chk({tag, ".t"}, 64'(bus.out_tag), 64'(t[3:0]));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int exp_ch [6];
        exp_ch = '{0, 1, 3, 0, 1, 3};
        rst_n         = 1'b0;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.in_tag    = '0;
        bus.flush     = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // reset state
        chk("rst.v", 64'(bus.out_valid), 64'd0);
        chk("rst.lvl", 64'(bus.level), 64'h0);
        chk("rst.rdy", 64'(bus.in_ready), 64'hF);
        chk("rst.d", 64'(bus.out_data), 64'h0);
        chk("rst.ch", 64'(bus.out_ch), 64'h0);

        // single entry latency
        bus.in_valid   = 4'b0001;
        bus.in_data[0] = 32'hDEADBEEF;
        bus.in_tag[0]  = 4'd3;
        bus.out_ready  = 1'b1;
        tick();
        bus.in_valid = '0;
        chk("lat.v1", 64'(bus.out_valid), 64'd0);
        chk("lat.lvl1", 64'(bus.level[0]), 64'd1);
        tick();
        chk_out("lat", 0, 32'hDEADBEEF, 3);
        chk("lat.lvl2", 64'(bus.level[0]), 64'd0);
        tick();
        chk("lat.v3", 64'(bus.out_valid), 64'd0);

        // fill ch1: first entry moves to the output register, 8 stay queued
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid   = 4'b0010;
            bus.in_data[1] = 32'h100 + i;
            bus.in_tag[1]  = 4'(i);
            if (i == 9) begin
                chk("fill.lvl", 64'(bus.level[1]), 64'd8);
                chk("fill.rdy", 64'(bus.in_ready[1]), 64'd0);
            end
            tick();
        end
        bus.in_valid = '0;
        chk("fill.drop", 64'(bus.level[1]), 64'd8);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk_out($sformatf("fill%0d", k), 1, 32'h100 + k, k);
            tick();
        end
        chk("fill.end", 64'(bus.out_valid), 64'd0);

        // round robin over ch0, ch1, ch3
        do_reset();
        bus.out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            bus.in_valid = 4'b1011;
            for (int c = 0; c < 4; c++) begin
                bus.in_data[c] = 32'(c * 16 + j);
                bus.in_tag[c]  = 4'(c);
            end
            tick();
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk_out($sformatf("rr%0d", k), exp_ch[k], 32'(exp_ch[k] * 16 + k / 3), exp_ch[k]);
            tick();
        end
        chk("rr.end", 64'(bus.out_valid), 64'd0);

        // stall with ch0 held and ch1, ch2 waiting
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b0111;
        for (int c = 0; c < 4; c++) begin
            bus.in_data[c] = 32'hA0 + c;
            bus.in_tag[c]  = 4'(c);
        end
        tick();
        bus.in_valid = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk_out($sformatf("stl%0d", k), 0, 32'hA0, 0);
            chk("stl.lvl", 64'(bus.level), 64'h0110);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk_out("stl.g1", 1, 32'hA1, 1);
        tick();
        chk_out("stl.g2", 2, 32'hA2, 2);
        tick();
        chk("stl.end", 64'(bus.out_valid), 64'd0);

        // flush ch2 while its oldest entry sits in the output register
        do_reset();
        bus.out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            bus.in_valid   = 4'b0100;
            bus.in_data[2] = 32'hC0 + j;
            bus.in_tag[2]  = 4'(j);
            tick();
        end
        chk("fl.lvl0", 64'(bus.level[2]), 64'd4);
        bus.flush      = 4'b0100;
        bus.in_data[2] = 32'hBAD;
        tick();
        bus.flush    = '0;
        bus.in_valid = '0;
        chk("fl.lvl1", 64'(bus.level[2]), 64'd0);
        chk_out("fl.out", 2, 32'hC0, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("fl.end", 64'(bus.out_valid), 64'd0);
        chk("fl.lvl2", 64'(bus.level[2]), 64'd0);

        // reset while busy
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        for (int c = 0; c < 4; c++) bus.in_data[c] = 32'hE0 + c;
        tick();
        tick();
        chk("mr.pre", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        bus.in_valid = '0;
        chk("mr.v", 64'(bus.out_valid), 64'd0);
        chk("mr.lvl", 64'(bus.level), 64'h0);
        chk("mr.rdy", 64'(bus.in_ready), 64'hF);
        chk("mr.d", 64'(bus.out_data), 64'h0);
        bus.in_valid   = 4'b0101;
        bus.in_data[0] = 32'hF0;
        bus.in_data[2] = 32'hF2;
        bus.in_tag[0]  = 4'd0;
        bus.in_tag[2]  = 4'd2;
        bus.out_ready  = 1'b1;
        tick();
        bus.in_valid = '0;
        chk("mr.v1", 64'(bus.out_valid), 64'd0);
        chk("mr.lvl1", 64'(bus.level), 64'h0101);
        tick();
        chk_out("mr.g0", 0, 32'hF0, 0);
        tick();
        chk_out("mr.g1", 2, 32'hF2, 2);
        tick();
        chk("mr.end", 64'(bus.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
